// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative signed multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Iteration counter width; never below one bit so tiny widths still elaborate.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration of the shared datapath: shift-add multiply or
// restoring divide, selected by mode.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             mode,     // 0 = multiply, 1 = divide
  input  logic [WIDTH-1:0] acc_in,   // product upper half / partial remainder
  input  logic [WIDTH-1:0] quo_in,   // multiplier bits / dividend-quotient bits
  input  logic [WIDTH-1:0] operand,  // multiplicand / divisor magnitude
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             take;

  // Compute both step flavours and pick one by mode.
  // NOTE: every output of a combinational block is assigned on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    acc_out   = acc_in;
    quo_out   = quo_in;
    // Multiply: conditionally add multiplicand into upper half, carry kept in sum[WIDTH].
    sum       = {1'b0, acc_in} + (quo_in[0] ? {1'b0, operand} : '0);
    // Divide: shift {rem,quo} left; the bit shifted out of rem is the trial MSB.
    rem_shift = {acc_in[WIDTH-2:0], quo_in[WIDTH-1]};
    take      = {acc_in[WIDTH-1], rem_shift} >= {1'b0, operand};
    rem_sub   = rem_shift - operand;
    if (mode == OP_MULT) begin
      acc_out = sum[WIDTH:1];
      quo_out = {sum[0], quo_in[WIDTH-1:1]};
    end else begin
      acc_out = take ? rem_sub : rem_shift;
      quo_out = {quo_in[WIDTH-2:0], take};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV unit with HI/LO registers (MTHI/MTLO writable).
// Start-to-done latency is WIDTH+2 cycles; DIV by zero finishes the next cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                op_q;
  logic               sign_q, sign_r;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   work_hi, work_lo, operand_q;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic               div_by_zero;

  // Magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned, no loss.
  assign abs_a       = a[WIDTH-1] ? -a : a;
  assign abs_b       = b[WIDTH-1] ? -b : b;
  assign div_by_zero = (op == OP_DIV) && (b == '0);
  assign prod        = {work_hi, work_lo};
  assign prod_neg    = -prod;

  assign busy = (state_q == ITER) || (state_q == FIX);
  assign done = (state_q == DONE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode    (op_q),
    .acc_in  (work_hi),
    .quo_in  (work_lo),
    .operand (operand_q),
    .acc_out (step_hi),
    .quo_out (step_lo)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing; a starting DIV by zero skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = div_by_zero ? DONE : ITER;
      ITER:    if (cnt == LAST_CNT) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration, sign fixup and HI/LO writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_MULT;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      cnt       <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      operand_q <= '0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= op_e'(op);
            sign_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r    <= a[WIDTH-1];
            cnt       <= '0;
            div_zero  <= div_by_zero;
            work_hi   <= '0;
            // Multiply shifts the multiplier out of work_lo; divide shifts the dividend.
            work_lo   <= (op == OP_DIV) ? abs_a : abs_b;
            operand_q <= (op == OP_DIV) ? abs_b : abs_a;
          end else begin
            if (hi_wr) hi <= wdata;
            if (lo_wr) lo <= wdata;
          end
        end
        ITER: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (op_q == OP_MULT) begin
            {hi, lo} <= sign_q ? prod_neg : prod;
          end else begin
            // Truncating division: remainder follows the dividend's sign.
            lo <= sign_q ? -work_lo : work_lo;
            hi <= sign_r ? -work_hi : work_hi;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
